// File: rtl/vx_scan_pkg.sv
// vx_scan_pkg: scan operator encodings and the per-operator identity (fill) bit.
package vx_scan_pkg;
  localparam int SCAN_OP_BITS = 2;
  typedef enum logic [SCAN_OP_BITS-1:0] {
    SCAN_OP_XOR  = 2'd0,
    SCAN_OP_AND  = 2'd1,
    SCAN_OP_OR   = 2'd2,
    SCAN_OP_PASS = 2'd3
  } scan_op_e;
  function automatic logic scan_identity(input logic [SCAN_OP_BITS-1:0] op);
    return op == SCAN_OP_AND;
  endfunction
endpackage

// File: rtl/vx_scan_level.sv
// vx_scan_level: one combinational Kogge-Stone level, combining each bit with its neighbour DIST away.
module vx_scan_level import vx_scan_pkg::*; #(
  parameter int N       = 8,
  parameter int DIST    = 1,
  parameter int REVERSE = 0
) (
  input  logic [N-1:0]            vec,
  input  logic [SCAN_OP_BITS-1:0] op,
  output logic [N-1:0]            res
);
  logic         id;
  logic [N-1:0] sh;
  always_comb begin
    id  = scan_identity(op);
    sh  = REVERSE != 0 ? (vec >> DIST) | ({N{id}} & ~({N{1'b1}} >> DIST))
                       : (vec << DIST) | ({N{id}} & ~({N{1'b1}} << DIST));
    res = op == SCAN_OP_XOR ? vec ^ sh :
          op == SCAN_OP_AND ? vec & sh :
          op == SCAN_OP_OR  ? vec | sh : vec;
  end
endmodule

// File: rtl/vx_scan_pipe.sv
// vx_scan_pipe: elastic pipelined prefix scan; VX_SCAN_PERF_EN adds perf_reqs/perf_stalls counters.
module vx_scan_pipe import vx_scan_pkg::*; #(
  parameter int N                = 8,
  parameter int REVERSE          = 0,
  parameter int LEVELS_PER_STAGE = 1,
  parameter int TAG_WIDTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [N-1:0]            data_in,
  input  logic [SCAN_OP_BITS-1:0] op_in,
  input  logic                    excl_in,
  input  logic [TAG_WIDTH-1:0]    tag_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [N-1:0]            data_out,
  output logic [TAG_WIDTH-1:0]    tag_out
`ifdef VX_SCAN_PERF_EN
  ,
  output logic [31:0]             perf_reqs,
  output logic [31:0]             perf_stalls
`endif
);
  localparam int LEVELS = $clog2(N);
  localparam int S      = LEVELS == 0 ? 1 : (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int LV     = LEVELS == 0 ? 1 : LEVELS;
  logic [S-1:0]            v;
  logic [N-1:0]            d  [S];
  logic [SCAN_OP_BITS-1:0] o  [S];
  logic                    x  [S];
  logic [TAG_WIDTH-1:0]    t  [S];
  logic [S:0]              adv;
  logic                    vi [S];
  logic                    xi [S];
  logic [N-1:0]            di [S];
  logic [N-1:0]            nd [S];
  logic [SCAN_OP_BITS-1:0] oi [S];
  logic [TAG_WIDTH-1:0]    ti [S];
  logic [N-1:0]            lo [LV];
  assign adv[S]    = ready_out;
  assign ready_in  = adv[0];
  assign valid_out = v[S-1];
  assign data_out  = d[S-1];
  assign tag_out   = t[S-1];
  if (LEVELS == 0) begin : g_nolvl
    assign lo[0] = di[0];
  end else begin : g_lvls
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int K = l / LEVELS_PER_STAGE;
      logic [N-1:0] src;
      if (l % LEVELS_PER_STAGE == 0) begin : g_first
        assign src = di[K];
      end else begin : g_chain
        assign src = lo[l-1];
      end
      vx_scan_level #(.N(N), .DIST(1 << l), .REVERSE(REVERSE)) u_lvl (
        .vec(src), .op(oi[K]), .res(lo[l])
      );
    end
  end
  for (genvar k = 0; k < S; k++) begin : g_stg
    localparam int END  = (k + 1) * LEVELS_PER_STAGE < LEVELS ? (k + 1) * LEVELS_PER_STAGE : LEVELS;
    localparam int LAST = LEVELS == 0 ? 0 : END - 1;
    if (k == 0) begin : g_head
      assign vi[0] = valid_in;
      assign di[0] = data_in;
      assign oi[0] = op_in;
      assign xi[0] = excl_in;
      assign ti[0] = tag_in;
    end else begin : g_body
      assign vi[k] = v[k-1];
      assign di[k] = d[k-1];
      assign oi[k] = o[k-1];
      assign xi[k] = x[k-1];
      assign ti[k] = t[k-1];
    end
    assign adv[k] = ~v[k] | adv[k+1];
    // exclusive: shift the finished inclusive result one place, identity into the vacated end
    if (k == S - 1) begin : g_excl
      logic id;
      logic [N-1:0] inc;
      always_comb begin
        id    = scan_identity(oi[k]);
        inc   = lo[LAST];
        nd[k] = !(xi[k] && oi[k] != SCAN_OP_PASS) ? inc :
                REVERSE != 0 ? (inc >> 1) | ({N{id}} & ~({N{1'b1}} >> 1))
                             : (inc << 1) | ({N{id}} & ~({N{1'b1}} << 1));
      end
    end else begin : g_mid
      assign nd[k] = lo[LAST];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < S; i++) begin
        d[i] <= '0;
        o[i] <= '0;
        x[i] <= 1'b0;
        t[i] <= '0;
      end
    end else begin
      for (int i = 0; i < S; i++) begin
        if (adv[i]) begin
          v[i] <= vi[i];
          if (vi[i]) begin
            d[i] <= nd[i];
            o[i] <= oi[i];
            x[i] <= xi[i];
            t[i] <= ti[i];
          end
        end
      end
    end
  end
`ifdef VX_SCAN_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_reqs   <= '0;
      perf_stalls <= '0;
    end else begin
      perf_reqs   <= perf_reqs + 32'(valid_in & ready_in);
      perf_stalls <= perf_stalls + 32'(valid_out & ~ready_out);
    end
  end
`endif
endmodule

// File: tb/tb_vx_scan_pipe.sv
// tb_vx_scan_pipe: forward and reverse instances share stimulus; results scored against a fold model.
module tb_vx_scan_pipe;
  logic clk = 1'b0, reset = 1'b1, valid_in = 1'b0, ready_out = 1'b0, excl_in = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] op_in = '0;
  logic [3:0] tag_in = '0;
  logic ready_in, valid_out, ready_in_r, valid_out_r;
  logic [7:0] data_out, data_out_r;
  logic [3:0] tag_out, tag_out_r;
`ifdef VX_SCAN_PERF_EN
  logic [31:0] perf_reqs, perf_stalls, perf_reqs_r, perf_stalls_r;
  logic [31:0] p0;
`endif
  always #5 clk = ~clk;

  vx_scan_pipe #(.N(8), .REVERSE(0), .LEVELS_PER_STAGE(1), .TAG_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .op_in(op_in), .excl_in(excl_in), .tag_in(tag_in), .valid_out(valid_out), .ready_out(ready_out),
    .data_out(data_out), .tag_out(tag_out)
`ifdef VX_SCAN_PERF_EN
    , .perf_reqs(perf_reqs), .perf_stalls(perf_stalls)
`endif
  );
  vx_scan_pipe #(.N(8), .REVERSE(1), .LEVELS_PER_STAGE(1), .TAG_WIDTH(4)) dut_r (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in_r), .data_in(data_in),
    .op_in(op_in), .excl_in(excl_in), .tag_in(tag_in), .valid_out(valid_out_r), .ready_out(ready_out),
    .data_out(data_out_r), .tag_out(tag_out_r)
`ifdef VX_SCAN_PERF_EN
    , .perf_reqs(perf_reqs_r), .perf_stalls(perf_stalls_r)
`endif
  );

  typedef struct {logic [7:0] f; logic [7:0] r; logic [3:0] t; int c; bit l;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_err = 0, cyc_n = 0, n_tx = 0, n_rx = 0;
  logic [7:0] exp_f, exp_r, hd;
  logic [3:0] ht;
  bit lat_en = 1'b0, hold = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // out[i] folds the inputs covered by bit i (excluding i itself when exclusive)
  function automatic logic [7:0] model(input logic [7:0] dv, input logic [1:0] op, input bit ex, input bit rev);
    logic [7:0] r;
    logic acc;
    if (op == 2'd3) return dv;
    for (int i = 0; i < 8; i++) begin
      acc = (op == 2'd1);
      for (int j = 0; j < 8; j++)
        if (rev ? (j >= i + int'(ex)) : (j <= i - int'(ex)))
          acc = op == 2'd0 ? acc ^ dv[j] : op == 2'd1 ? acc & dv[j] : acc | dv[j];
      r[i] = acc;
    end
    return r;
  endfunction

  task automatic drive_rand();
    data_in = 8'($urandom);
    op_in   = 2'($urandom_range(0, 3));
    excl_in = 1'($urandom_range(0, 1));
    tag_in  = 4'($urandom);
    exp_f   = model(data_in, op_in, excl_in, 1'b0);
    exp_r   = model(data_in, op_in, excl_in, 1'b1);
  endtask

  task automatic cyc();
    exp_t e;
    #1;
    if (!reset) begin
      if (hold) begin
        check("hold_valid", 32'(valid_out), 32'd1);
        check("hold_data", 32'(data_out), 32'(hd));
        check("hold_tag", 32'(tag_out), 32'(ht));
      end
      if (valid_out && ready_out) begin
        if (q.size() == 0) check("spurious_out", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("data_fwd", 32'(data_out), 32'(e.f));
          check("tag_fwd", 32'(tag_out), 32'(e.t));
          check("valid_rev", 32'(valid_out_r), 32'd1);
          check("data_rev", 32'(data_out_r), 32'(e.r));
          check("tag_rev", 32'(tag_out_r), 32'(e.t));
          if (e.l) check("latency", 32'(cyc_n - e.c), 32'd3);
          n_rx++;
        end
      end
      if (valid_in && ready_in) begin
        q.push_back('{exp_f, exp_r, tag_in, cyc_n, lat_en});
        n_tx++;
      end
    end
    hold = !reset && valid_out && !ready_out;
    hd = data_out;
    ht = tag_out;
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic fill3();
    ready_out = 1'b0;
    for (int b = 0; b < 10 && q.size() < 3; b++) begin
      valid_in = 1'b1;
      drive_rand();
      cyc();
    end
    valid_in = 1'b0;
    check("fill3", 32'(q.size()), 32'd3);
  endtask

  logic [7:0] dd [6] = '{8'h06, 8'h06, 8'h06, 8'hF7, 8'h06, 8'h06};
  logic [1:0] dop[6] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd0, 2'd3};
  logic       dex[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] df [6] = '{8'h02, 8'hFE, 8'hFC, 8'h07, 8'h04, 8'h06};
  logic [7:0] dr [6] = '{8'h04, 8'h07, 8'h03, 8'hF0, 8'h02, 8'h06};

  initial begin
    int sent, pre;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_tag", 32'(tag_out), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    @(negedge clk);

    ready_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      data_in = dd[i]; op_in = dop[i]; excl_in = dex[i]; tag_in = 4'(i + 5);
      exp_f = df[i]; exp_r = dr[i]; lat_en = (i == 0);
      cyc();
    end
    valid_in = 1'b0;
    lat_en = 1'b0;
    repeat (6) cyc();
    check("directed_drain", 32'(q.size()), 32'd0);

    fill3();
    check("full_ready_in", 32'(ready_in), 32'd0);
`ifdef VX_SCAN_PERF_EN
    p0 = perf_stalls;
`endif
    for (int i = 0; i < 10; i++) begin
      check("stall_ready_in", 32'(ready_in), 32'd0);
      cyc();
    end
`ifdef VX_SCAN_PERF_EN
    check("perf_stalls_delta", perf_stalls - p0, 32'd10);
`endif
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", 32'(valid_out), 32'd1);
      cyc();
    end
    check("drain3_empty", 32'(q.size()), 32'd0);

    sent = 0;
    for (int b = 0; b < 400 && sent < 40; b++) begin
      ready_out = 1'($urandom_range(0, 1));
      valid_in = 1'b1;
      drive_rand();
      pre = n_tx;
      cyc();
      if (n_tx > pre) sent++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    for (int b = 0; b < 30 && q.size() > 0; b++) cyc();
    check("random_drain", 32'(q.size()), 32'd0);
    check("rx_eq_tx", 32'(n_rx), 32'(n_tx));
`ifdef VX_SCAN_PERF_EN
    check("perf_reqs", perf_reqs, 32'(n_tx));
`endif

    fill3();
    reset = 1'b1;
    cyc();
    q.delete();
    check("midrst_valid", 32'(valid_out), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_ready_in", 32'(ready_in), 32'd1);
`ifdef VX_SCAN_PERF_EN
    check("midrst_perf_reqs", perf_reqs, 32'd0);
    check("midrst_perf_stalls", perf_stalls, 32'd0);
`endif
    reset = 1'b0;
    ready_out = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("post_rst_idle", 32'(valid_out), 32'd0);
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vx_scan_pipe.md
Name: VX_scan_pipe

Overview:
Pipelined, elastic prefix-scan engine for thread-mask and predicate processing (active-lane compaction, leader election, priority masks).
- Kogge-Stone tree over N bits, split into registered stages.
- Operator and inclusive/exclusive mode are selectable per request at runtime.
- Requests carry a tag through the pipe; valid/ready on both sides with full backpressure.

Parameters:
N, 8, scan width in bits (>=1)
REVERSE, 0, 0: LO->HI (out[i] covers in[0..i]); 1: HI->LO (out[i] covers in[i..N-1])
LEVELS_PER_STAGE, 1, tree levels per register stage (>=1)
TAG_WIDTH, 4, opaque sideband width (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  request valid
ready_in  out  1  request accepted when valid_in & ready_in
data_in  in  N  operand
op_in  in  2  0 XOR, 1 AND, 2 OR, 3 PASS
excl_in  in  1  1 = exclusive scan
tag_in  in  TAG_WIDTH  sideband
valid_out  out  1  result valid
ready_out  in  1  consumer ready
data_out  out  N  scan result
tag_out  out  TAG_WIDTH  tag of the result

Behaviour:
- One clock domain; reset is synchronous and active-high, on clk/reset.
- Pipeline geometry:
  - LEVELS = clog2(N).
  - S = (LEVELS==0) ? 1 : ceil(LEVELS/LEVELS_PER_STAGE).
  - Stage k holds a valid bit, partial vector, op, excl and tag.
- Latency: an accepted request appears on valid_out exactly S cycles later when there are no stalls (N=8, LPS=1 -> 3 cycles).
- Level i combines t with t shifted by 2^i toward the scan direction. Fill value is the operator identity: XOR/OR 0, AND 1.
- PASS: data_out = data_in unchanged; excl is ignored.
- Exclusive mode:
  - Applied in the final stage.
  - The inclusive result is shifted one position in the scan direction.
  - The vacated end (bit 0 for LO->HI, bit N-1 for HI->LO) is filled with the identity.
- Handshake:
  - Each stage advances independently: adv_k = ~v_k | adv_{k+1}, where adv_S = ready_out.
  - ready_in = adv_0. Bubbles collapse.
  - Peak throughput is 1 request/cycle.
  - The ready path is combinational from ready_out.
- Outputs:
  - data_out, tag_out and valid_out come straight from the last stage register.
  - They stay stable while valid_out & ~ready_out.
- A request with valid_in=0 never writes stage data. The stage valid clears only when the stage advances.
- Simultaneous accept and emit on a full pipe with ready_out=1: both occur in the same cycle with no bubble.
- Reset:
  - All valid bits go to 0; data_out and tag_out go to 0.
  - Reset mid-operation discards in-flight requests.
  - ready_in = 1 in the first cycle after reset.
- N=1:
  - Result equals the input for XOR/AND/OR/PASS inclusive.
  - Exclusive gives the identity.
  - One register stage.
- op_in is sampled only on accept and is carried per request, so mixed ops in flight are legal.

Optional Feature:
- Macro: VX_SCAN_PERF_EN.
- Defined:
  - Extra outputs perf_reqs (32b, accepted requests) and perf_stalls (32b, cycles with valid_out & ~ready_out).
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package VX_scan_pkg:
  - Op encodings SCAN_OP_XOR=0, SCAN_OP_AND=1, SCAN_OP_OR=2, SCAN_OP_PASS=3.
  - Width constant SCAN_OP_BITS=2.
  - Function scan_identity(op) returning the fill bit.
- Sub-module VX_scan_level:
  - Purely combinational, one tree level.
  - Parameters N, DIST, REVERSE; inputs vector and op; output vector.
  - Instantiated LEVELS times and grouped into stages by a generate loop.

Test Plan:
- N=8, REVERSE=0, XOR, inclusive, data 8'b0000_0110 -> 8'b0000_0010 after 3 cycles, tag preserved.
- OR on 8'b0000_0110 -> 8'b1111_1110. Same with excl=1 -> 8'b1111_1100. AND on 8'b1111_0111 -> 8'b0000_0111.
- REVERSE=1, XOR on 8'b0000_0110 -> 8'b0000_0100. Exclusive -> 8'b0000_0010. PASS with excl=1 -> 8'b0000_0110.
- Back-to-back 16 requests with mixed ops, ready_out random 50%:
  - All results are in order and correct per op.
  - No loss or duplication.
  - Outputs are held stable while stalled.
- Pipe full, ready_out=0 for 10 cycles:
  - ready_in=0.
  - With VX_SCAN_PERF_EN, perf_stalls increments by 10.
  - Then ready_out=1 drains 3 results on consecutive cycles.
- Assert reset with 3 requests in flight:
  - Next cycle valid_out=0, data_out=0, ready_in=1.
  - No stale result appears afterwards; perf counters are 0.
